wb_rr_sched: RTL and testbench

Four-requester round-robin Wishbone scheduler that shares one downstream Wishbone port (the address-decode/slave-mux stage) among PCIe, SGDMA and two auxiliary masters. It grants whole cycles (cyc-framed, burst-safe), rotates priority after every completed ownership, and optionally terminates hung transfers with a watchdog error, latching which master was hit.

---
 rtl/wb_rr_sched.sv | 205 ++++++++++++++++++++
 tb/tb_wb_rr_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_sched.sv
// wb_rr_sched: four-master round-robin Wishbone scheduler feeding one
// downstream port. Ownership is granted for a whole cyc frame, so bursts are
// never split. After each completed ownership the priority rotates.
//
// Optional build macro WB_RR_SCHED_WATCHDOG_EN adds a watchdog. If a strobe
// goes TIMEOUT cycles with no termination, the watchdog answers the owner
// with err for one cycle and latches the owner index in a sticky flag.
// Without the macro, to_flag_o and to_id_o stay 0 and to_clr_i is ignored.
module wb_rr_sched #(
    parameter int unsigned c_DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    m_cyc_i,
    input  logic [3:0]                    m_stb_i,
    input  logic [3:0]                    m_we_i,
    input  logic [4*32-1:0]               m_adr_i,
    input  logic [4*c_DATA_WIDTH-1:0]     m_dat_i,
    input  logic [4*(c_DATA_WIDTH/8)-1:0] m_sel_i,
    input  logic [4*3-1:0]                m_cti_i,
    output logic [c_DATA_WIDTH-1:0]       m_dat_o,
    output logic [3:0]                    m_ack_o,
    output logic [3:0]                    m_err_o,
    output logic [3:0]                    m_rty_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [31:0]                   s_adr_o,
    output logic [c_DATA_WIDTH-1:0]       s_dat_o,
    output logic [c_DATA_WIDTH/8-1:0]     s_sel_o,
    output logic [2:0]                    s_cti_o,
    input  logic [c_DATA_WIDTH-1:0]       s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
    output logic [3:0]                    gnt_o,
    output logic                          to_flag_o,
    output logic [1:0]                    to_id_o,
    input  logic                          to_clr_i
);

    localparam int unsigned SEL_W = c_DATA_WIDTH / 8;
    localparam int unsigned NUM_M = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [3:0] gnt;
    logic [3:0] gnt_nxt;
    logic [1:0] last;
    logic [1:0] last_nxt;
    logic [1:0] owner_idx;
    logic [1:0] pick;
    logic       pick_vld;
    logic       wd_fire;
    logic       term;

    assign term  = s_ack_i | s_err_i | s_rty_i;
    assign gnt_o = gnt;

    // Encode the one-hot grant into the owner index.
    always_comb begin
        owner_idx = 2'd0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt[i]) begin
                owner_idx = 2'(i);
            end
        end
    end

    // Round-robin search: last+1, last+2, last+3, then last itself.
    // Walking the offsets from highest to lowest leaves the nearest hit.
    always_comb begin
        pick     = last;
        pick_vld = 1'b0;
        for (int k = NUM_M; k >= 1; k--) begin
            if (m_cyc_i[last + 2'(k)]) begin
                pick     = last + 2'(k);
                pick_vld = 1'b1;
            end
        end
    end

    // Scheduler state, grant and rotation pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'd0;
            last  <= 2'd3;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end

    // Next state: grant from IDLE. Hold the grant until the owner drops cyc.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = OWN;
                    gnt_nxt   = 4'd1 << pick;
                end else begin
                    gnt_nxt   = 4'd0;
                end
            end
            OWN: begin
                if (!m_cyc_i[owner_idx]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'd0;
                    last_nxt  = owner_idx;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'd0;
            end
        endcase
    end

    // Downstream mux and termination routing, both keyed off the registered grant.
    // A watchdog fire masks the downstream strobe and answers the owner with err.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = 32'd0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = 3'd0;
        m_ack_o = 4'd0;
        m_err_o = 4'd0;
        m_rty_o = 4'd0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt[i]) begin
                s_cyc_o    = m_cyc_i[i] & ~wd_fire;
                s_stb_o    = m_cyc_i[i] & m_stb_i[i] & ~wd_fire;
                s_we_o     = m_we_i[i];
                s_adr_o    = m_adr_i[32*i +: 32];
                s_dat_o    = m_dat_i[c_DATA_WIDTH*i +: c_DATA_WIDTH];
                s_sel_o    = m_sel_i[SEL_W*i +: SEL_W];
                s_cti_o    = m_cti_i[3*i +: 3];
                m_ack_o[i] = s_ack_i & ~wd_fire;
                m_err_o[i] = s_err_i | wd_fire;
                m_rty_o[i] = s_rty_i & ~wd_fire;
            end
        end
    end

    assign m_dat_o = s_dat_i;

`ifdef WB_RR_SCHED_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             to_flag;
    logic [1:0]       to_id;

    // Watchdog: count stalled strobe cycles. When the count reaches TIMEOUT,
    // raise a one-cycle fire, then record it in the sticky flag. A fire
    // outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            wd_fire <= 1'b0;
            to_flag <= 1'b0;
            to_id   <= 2'd0;
        end else begin
            wd_fire <= 1'b0;
            if ((state == OWN) && s_stb_o && !term) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
                if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                    wd_fire <= 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
            if (wd_fire) begin
                to_flag <= 1'b1;
                to_id   <= owner_idx;
            end else if (to_clr_i) begin
                to_flag <= 1'b0;
            end
        end
    end

    assign to_flag_o = to_flag;
    assign to_id_o   = to_id;
`else
    logic [31:0] unused_sink;

    assign wd_fire     = 1'b0;
    assign to_flag_o   = 1'b0;
    assign to_id_o     = 2'd0;
    assign unused_sink = 32'(TIMEOUT) ^ {31'd0, to_clr_i};
`endif

endmodule

// File: tb/tb_wb_rr_sched.sv
// Randomized bench for wb_rr_sched, checked cycle by cycle against a
// behavioural scheduler model. Honours WB_RR_SCHED_WATCHDOG_EN.
module tb_wb_rr_sched;

    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int          TO = 16;
    localparam int          NCYC = 3000;
`ifdef WB_RR_SCHED_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [4*32-1:0] m_adr_i;
    logic [4*DW-1:0] m_dat_i;
    logic [4*SW-1:0] m_sel_i;
    logic [4*3-1:0]  m_cti_i;
    logic [DW-1:0]   m_dat_o;
    logic [3:0]      m_ack_o, m_err_o, m_rty_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]     s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [2:0]      s_cti_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [3:0]      gnt_o;
    logic            to_flag_o;
    logic [1:0]      to_id_o;
    logic            to_clr_i;

    wb_rr_sched #(.c_DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .to_flag_o(to_flag_o), .to_id_o(to_id_o), .to_clr_i(to_clr_i)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: owner index (-1 = nobody), last owner, stall count, flag.
    int   owner, last, wd, tid;
    bit   flag, fire;
    logic e_stb;
    logic [3:0] e_ack, e_err, e_rty;

    // Master agents.
    bit a_cyc[4];
    bit a_stb[4];
    int a_beats[4];
    int phase;   // 0 rotation, 1 random, 2 silent slave, 3 random with resets

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_inputs(input int c);
        int r;
        phase = (c < 60) ? 0 : (c < 800) ? 1 : (c < 900) ? 2 : 3;
        for (int i = 0; i < 4; i++) begin
            m_cyc_i[i]          = a_cyc[i];
            m_stb_i[i]          = a_stb[i];
            m_we_i[i]           = 1'($urandom);
            m_adr_i[32*i +: 32] = $urandom;
            m_dat_i[DW*i +: DW] = {$urandom, $urandom};
            m_sel_i[SW*i +: SW] = SW'($urandom);
            m_cti_i[3*i +: 3]   = 3'($urandom);
        end
        s_dat_i = {$urandom, $urandom};
        r = int'($urandom_range(0, 15));
        case (phase)
            0:       begin s_ack_i = 1'b1; s_err_i = 1'b0; s_rty_i = 1'b0; end
            2:       begin s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; end
            default: begin s_ack_i = (r < 7); s_err_i = (r == 7); s_rty_i = (r == 8); end
        endcase
        // In the silent phase, aim a clear at every predicted fire.
        if (phase == 2)
            to_clr_i = (owner >= 0 && wd == TO) || ($urandom_range(0, 7) == 0);
        else
            to_clr_i = ($urandom_range(0, 31) == 0);
        rst = (phase == 3) && ($urandom_range(0, 149) == 0);
    endtask

    task automatic check_outputs();
        logic [3:0]    e_gnt;
        logic          e_cyc, e_we;
        logic [31:0]   e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [2:0]    e_cti;
        fire  = WD_ON && owner >= 0 && wd == TO;
        e_gnt = 4'd0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0;
        e_ack = 4'd0; e_err = 4'd0; e_rty = 4'd0;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            e_cyc = m_cyc_i[owner] && !fire;
            e_stb = e_cyc && m_stb_i[owner];
            e_we  = m_we_i[owner];
            e_adr = m_adr_i[32*owner +: 32];
            e_dat = m_dat_i[DW*owner +: DW];
            e_sel = m_sel_i[SW*owner +: SW];
            e_cti = m_cti_i[3*owner +: 3];
            e_ack[owner] = s_ack_i && !fire;
            e_err[owner] = s_err_i || fire;
            e_rty[owner] = s_rty_i && !fire;
        end
        check_eq("gnt",     64'(gnt_o),     64'(e_gnt));
        check_eq("s_cyc",   64'(s_cyc_o),   64'(e_cyc));
        check_eq("s_stb",   64'(s_stb_o),   64'(e_stb));
        check_eq("s_we",    64'(s_we_o),    64'(e_we));
        check_eq("s_adr",   64'(s_adr_o),   64'(e_adr));
        check_eq("s_dat",   64'(s_dat_o),   64'(e_dat));
        check_eq("s_sel",   64'(s_sel_o),   64'(e_sel));
        check_eq("s_cti",   64'(s_cti_o),   64'(e_cti));
        check_eq("m_ack",   64'(m_ack_o),   64'(e_ack));
        check_eq("m_err",   64'(m_err_o),   64'(e_err));
        check_eq("m_rty",   64'(m_rty_o),   64'(e_rty));
        check_eq("m_dat",   64'(m_dat_o),   64'(s_dat_i));
        check_eq("to_flag", 64'(to_flag_o), 64'(flag));
        check_eq("to_id",   64'(to_id_o),   64'(tid));
    endtask

    task automatic step_agents();
        for (int i = 0; i < 4; i++) begin
            if (a_cyc[i]) begin
                if (a_stb[i] && (e_ack[i] || e_err[i])) a_beats[i]--;
                if (e_err[i] || a_beats[i] <= 0) begin
                    a_cyc[i] = 1'b0; a_stb[i] = 1'b0;
                end else if ((phase == 1 || phase == 3) && $urandom_range(0, 99) == 0) begin
                    a_cyc[i] = 1'b0; a_stb[i] = 1'b0;
                end else begin
                    a_stb[i] = (phase == 0 || phase == 2) ? 1'b1 : ($urandom_range(0, 7) != 0);
                end
            end else if (phase == 0 || phase == 2 || $urandom_range(0, 3) == 0) begin
                a_cyc[i]   = 1'b1;
                a_stb[i]   = 1'b1;
                a_beats[i] = (phase == 0) ? 1 : int'($urandom_range(1, 8));
            end
        end
    endtask

    task automatic step_model();
        if (rst) begin
            owner = -1; last = 3; wd = 0; flag = 1'b0; tid = 0;
        end else if (owner >= 0) begin
            if (fire) begin
                flag = 1'b1; tid = owner; wd = 0;
            end else begin
                if (to_clr_i) flag = 1'b0;
                wd = (e_stb && !(s_ack_i || s_err_i || s_rty_i)) ? wd + 1 : 0;
            end
            if (!m_cyc_i[owner]) begin
                last = owner; owner = -1; wd = 0;
            end
        end else begin
            if (to_clr_i) flag = 1'b0;
            wd = 0;
            for (int k = 4; k >= 1; k--)
                if (m_cyc_i[(last + k) % 4]) owner = (last + k) % 4;
        end
    endtask

    initial begin
        rst = 1'b1; to_clr_i = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0;
        m_dat_i = '0; m_sel_i = '0; m_cti_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_cyc[i] = 1'b0; a_stb[i] = 1'b0; a_beats[i] = 0;
        end
        owner = -1; last = 3; wd = 0; flag = 1'b0; tid = 0; phase = 0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            drive_inputs(c);
            #1;
            check_outputs();
            step_agents();
            step_model();
            @(posedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
